// File: rtl/spidergon_traffic_gen_pkg.sv
// rtl/spidergon_traffic_gen_pkg.sv - shared widths, flit field helpers, pattern codes and FSM states
// Contents: dest_w/vc_w/seq_w/cnt_w width functions, flit_dest/flit_seq field slicers,
//           PAT_* destination pattern codes, state_t run-sequencer states.
package spidergon_pkg;

  localparam logic [1:0] PAT_FIXED = 2'd0;
  localparam logic [1:0] PAT_INCR  = 2'd1;
  localparam logic [1:0] PAT_OPP   = 2'd2;
  localparam logic [1:0] PAT_LFSR  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_INJECT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int dest_w(input int num_nodes);
    return $clog2(num_nodes);
  endfunction

  function automatic int vc_w(input int num_vcs);
    return (num_vcs <= 2) ? 1 : $clog2(num_vcs);
  endfunction

  function automatic int seq_w(input int flit_w, input int num_nodes);
    return flit_w - dest_w(num_nodes);
  endfunction

  function automatic int cnt_w(input int num_flits);
    return $clog2(num_flits + 1);
  endfunction

  // Flit layout is {dest, seq}; data is zero-extended into 64 bits by the caller.
  function automatic logic [31:0] flit_dest(input logic [63:0] data, input int flit_w,
                                            input int num_nodes);
    logic [63:0] w_mask;
    w_mask = (64'd1 << dest_w(num_nodes)) - 64'd1;
    return 32'((data >> seq_w(flit_w, num_nodes)) & w_mask);
  endfunction

  function automatic logic [31:0] flit_seq(input logic [63:0] data, input int flit_w,
                                           input int num_nodes);
    logic [63:0] w_mask;
    w_mask = (64'd1 << seq_w(flit_w, num_nodes)) - 64'd1;
    return 32'(data & w_mask);
  endfunction

endpackage

// File: rtl/spidergon_traffic_gen_if.sv
// rtl/spidergon_traffic_gen_if.sv - local inject/eject port between a generator and its NoC node
// Signals: flit_out_data/vc/valid/ready (inject, generator -> node),
//          flit_in_data/valid (eject, node -> generator, no backpressure).
// Modports: master = generator side, slave = node side.
interface spidergon_traffic_gen_if #(
  parameter int DATA_W = 16,
  parameter int VC_W   = 1
);
  logic [DATA_W-1:0] flit_out_data;
  logic [VC_W-1:0]   flit_out_vc;
  logic              flit_out_valid;
  logic              flit_out_ready;
  logic [DATA_W-1:0] flit_in_data;
  logic              flit_in_valid;

  modport master (
    output flit_out_data, flit_out_vc, flit_out_valid,
    input  flit_out_ready, flit_in_data, flit_in_valid
  );

  modport slave (
    input  flit_out_data, flit_out_vc, flit_out_valid,
    output flit_out_ready, flit_in_data, flit_in_valid
  );
endinterface

// File: rtl/spidergon_dest_gen.sv
// rtl/spidergon_dest_gen.sv - destination sequence for injected flits
// Ports: i_clk, i_reset (async, active-high), i_load (restart sequence, sample pattern/fixed_dest),
//        i_advance (current dest consumed), i_pattern, i_fixed_dest, o_dest (current destination).
module spidergon_dest_gen
  import spidergon_pkg::*;
#(
  parameter  int NUM_OF_NODES = 8,
  parameter  int SRC_NODE     = 0,
  localparam int DEST_W       = dest_w(NUM_OF_NODES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic [1:0]        i_pattern,
  input  logic [DEST_W-1:0] i_fixed_dest,
  output logic [DEST_W-1:0] o_dest
);

  localparam logic [DEST_W-1:0] SRC       = DEST_W'(SRC_NODE);
  localparam logic [DEST_W-1:0] SRC_ALT   = DEST_W'(SRC_NODE) ^ DEST_W'(1);
  localparam logic [DEST_W-1:0] LAST_NODE = DEST_W'(NUM_OF_NODES - 1);
  localparam logic [DEST_W-1:0] FIRST_INC = DEST_W'((SRC_NODE + 1) % NUM_OF_NODES);
  localparam logic [DEST_W-1:0] OPP       = DEST_W'((SRC_NODE + NUM_OF_NODES / 2) % NUM_OF_NODES);
  localparam logic [7:0]        LFSR_SEED = 8'hFF;
  // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0]        LFSR_MASK = 8'hB8;

  logic [1:0]        r_pattern;
  logic [DEST_W-1:0] r_fixed;
  logic [DEST_W-1:0] r_incr;
  logic [7:0]        r_lfsr;

  logic [DEST_W-1:0] w_inc1;
  logic [DEST_W-1:0] w_inc2;
  logic [DEST_W-1:0] w_incr_next;
  logic [7:0]        w_lfsr_next;
  logic [DEST_W-1:0] w_lfsr_dest;

  always_comb begin
    w_inc1 = (r_incr == LAST_NODE) ? '0 : r_incr + DEST_W'(1);
    w_inc2 = (w_inc1 == LAST_NODE) ? '0 : w_inc1 + DEST_W'(1);
    // Incrementing walk never targets the local node.
    w_incr_next = (w_inc1 == SRC) ? w_inc2 : w_inc1;
    w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_MASK : 8'h00);
    w_lfsr_dest = (r_lfsr[DEST_W-1:0] == SRC) ? SRC_ALT : r_lfsr[DEST_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pattern <= PAT_FIXED;
      r_fixed   <= '0;
      r_incr    <= FIRST_INC;
      r_lfsr    <= LFSR_SEED;
    end else if (i_load) begin
      r_pattern <= i_pattern;
      r_fixed   <= i_fixed_dest;
      r_incr    <= FIRST_INC;
      r_lfsr    <= LFSR_SEED;
    end else if (i_advance) begin
      r_incr <= w_incr_next;
      r_lfsr <= w_lfsr_next;
    end
  end

  always_comb begin
    o_dest = r_fixed;
    case (r_pattern)
      PAT_FIXED: o_dest = r_fixed;
      PAT_INCR:  o_dest = r_incr;
      PAT_OPP:   o_dest = OPP;
      PAT_LFSR:  o_dest = w_lfsr_dest;
      default:   o_dest = r_fixed;
    endcase
  end

endmodule

// File: rtl/spidergon_traffic_gen.sv
// rtl/spidergon_traffic_gen.sv - per-node NoC traffic generator and order-independent delivery checker
// Ports: i_clk, i_reset (async, active-high), i_start (pulse, honoured in IDLE/DONE),
//        i_pattern_sel, i_fixed_dest, o_noc_reset, flit_if (inject/eject port, master side),
//        o_sent_count, o_recv_count, o_done, o_pass (valid with o_done), o_timeout.
module spidergon_traffic_gen
  import spidergon_pkg::*;
#(
  parameter  int NUM_OF_NODES            = 8,
  parameter  int FLIT_DATA_WIDTH         = 16,
  parameter  int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter  int SRC_NODE                = 0,
  parameter  int RESET_HOLD_CYCLES       = 2,
  parameter  int NUM_FLITS               = 16,
  parameter  int RUN_TIMEOUT             = 30,
  localparam int DEST_W                  = dest_w(NUM_OF_NODES),
  localparam int VC_W                    = vc_w(NUM_OF_VIRTUAL_CHANNELS),
  localparam int SEQ_W                   = seq_w(FLIT_DATA_WIDTH, NUM_OF_NODES),
  localparam int CNT_W                   = cnt_w(NUM_FLITS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [1:0]             i_pattern_sel,
  input  logic [DEST_W-1:0]      i_fixed_dest,
  output logic                   o_noc_reset,
  spidergon_traffic_gen_if.master flit_if,
  output logic [CNT_W-1:0]       o_sent_count,
  output logic [CNT_W-1:0]       o_recv_count,
  output logic                   o_done,
  output logic                   o_pass,
  output logic                   o_timeout
);

  localparam int                HOLD_W    = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int                TO_W      = $clog2(RUN_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  FLITS_C   = CNT_W'(NUM_FLITS);
  localparam logic [VC_W-1:0]   VC_LAST   = VC_W'(NUM_OF_VIRTUAL_CHANNELS - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [HOLD_W-1:0]          r_hold;
  logic [TO_W-1:0]            r_to;
  logic [CNT_W-1:0]           r_sent;
  logic [CNT_W-1:0]           r_recv;
  logic [SEQ_W-1:0]           r_seq;
  logic [VC_W-1:0]            r_vc;
  logic [FLIT_DATA_WIDTH-1:0] r_sent_xor;
  logic [FLIT_DATA_WIDTH-1:0] r_recv_xor;
  logic                       r_overflow;
  logic                       r_done;
  logic                       r_pass;
  logic                       r_timeout;

  logic [DEST_W-1:0]          w_dest;
  logic [FLIT_DATA_WIDTH-1:0] w_flit;
  logic                       w_start;
  logic                       w_active;
  logic                       w_valid;
  logic                       w_accept;
  logic                       w_eject;
  logic                       w_recv_full;
  logic [CNT_W-1:0]           w_sent_next;
  logic [CNT_W-1:0]           w_recv_next;
  logic [FLIT_DATA_WIDTH-1:0] w_sent_xor_next;
  logic [FLIT_DATA_WIDTH-1:0] w_recv_xor_next;
  logic                       w_ovf_next;
  logic                       w_to_hit;
  logic                       w_complete;
  logic                       w_finish;

  spidergon_dest_gen #(
    .NUM_OF_NODES (NUM_OF_NODES),
    .SRC_NODE     (SRC_NODE)
  ) u_dest_gen (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_start),
    .i_advance    (w_accept),
    .i_pattern    (i_pattern_sel),
    .i_fixed_dest (i_fixed_dest),
    .o_dest       (w_dest)
  );

  always_comb begin
    w_start         = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    w_active        = (r_state == ST_INJECT) || (r_state == ST_DRAIN);
    w_valid         = (r_state == ST_INJECT);
    w_flit          = {w_dest, r_seq};
    w_accept        = w_valid && flit_if.flit_out_ready;
    w_eject         = w_active && flit_if.flit_in_valid;
    w_recv_full     = (r_recv == FLITS_C);
    w_sent_next     = w_accept ? r_sent + CNT_W'(1) : r_sent;
    w_sent_xor_next = w_accept ? r_sent_xor ^ w_flit : r_sent_xor;
    // Count saturates; anything beyond the expected total is flagged instead.
    w_recv_next     = (w_eject && !w_recv_full) ? r_recv + CNT_W'(1) : r_recv;
    w_recv_xor_next = w_eject ? r_recv_xor ^ flit_if.flit_in_data : r_recv_xor;
    w_ovf_next      = r_overflow || (w_eject && w_recv_full);
    w_to_hit        = w_active && (r_to == TO_LAST);
    // Completion looks at this cycle's eject so a final flit arriving with the
    // timeout still counts as a completed run.
    w_complete      = w_active && (w_sent_next == FLITS_C) && (w_recv_next == FLITS_C);
    w_finish        = w_complete || w_to_hit;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_state_next = ST_RST_HOLD;
      ST_RST_HOLD: if (r_hold == HOLD_LAST) w_state_next = ST_INJECT;
      ST_INJECT: begin
        if (w_finish) w_state_next = ST_DONE;
        else if (w_sent_next == FLITS_C) w_state_next = ST_DRAIN;
      end
      ST_DRAIN:    if (w_finish) w_state_next = ST_DONE;
      ST_DONE:     if (w_start) w_state_next = ST_RST_HOLD;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_to       <= '0;
      r_sent     <= '0;
      r_recv     <= '0;
      r_seq      <= '0;
      r_vc       <= '0;
      r_sent_xor <= '0;
      r_recv_xor <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_hold     <= '0;
        r_to       <= '0;
        r_sent     <= '0;
        r_recv     <= '0;
        r_seq      <= '0;
        r_vc       <= '0;
        r_sent_xor <= '0;
        r_recv_xor <= '0;
        r_overflow <= 1'b0;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
        r_timeout  <= 1'b0;
      end else if (r_state == ST_RST_HOLD) begin
        r_hold <= r_hold + HOLD_W'(1);
        r_to   <= '0;
      end else if (w_active) begin
        r_to       <= r_to + TO_W'(1);
        r_sent     <= w_sent_next;
        r_recv     <= w_recv_next;
        r_sent_xor <= w_sent_xor_next;
        r_recv_xor <= w_recv_xor_next;
        r_overflow <= w_ovf_next;
        if (w_accept) begin
          r_seq <= r_seq + SEQ_W'(1);
          r_vc  <= (r_vc == VC_LAST) ? '0 : r_vc + VC_W'(1);
        end
        if (w_finish) begin
          r_done    <= 1'b1;
          r_timeout <= !w_complete;
          r_pass    <= w_complete && !w_ovf_next && (w_sent_xor_next == w_recv_xor_next);
        end
      end
    end
  end

  assign o_noc_reset            = (r_state == ST_IDLE) || (r_state == ST_RST_HOLD);
  assign flit_if.flit_out_valid = w_valid;
  assign flit_if.flit_out_data  = w_valid ? w_flit : '0;
  assign flit_if.flit_out_vc    = w_valid ? r_vc : '0;
  assign o_sent_count           = r_sent;
  assign o_recv_count           = r_recv;
  assign o_done                 = r_done;
  assign o_pass                 = r_pass;
  assign o_timeout              = r_timeout;

endmodule

// File: tb/tb_spidergon_traffic_gen.sv
// tb/tb_spidergon_traffic_gen.sv - directed bench for spidergon_traffic_gen with loopback eject
module tb_spidergon_traffic_gen;
  import spidergon_pkg::*;

  localparam int FW = 16;
  localparam int DW = 3;
  localparam int VW = 1;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic [DW-1:0] fixed_dest = '0;
  logic          noc_reset;
  logic [CW-1:0] sent_count;
  logic [CW-1:0] recv_count;
  logic          done;
  logic          pass;
  logic          timeout;

  spidergon_traffic_gen_if #(.DATA_W(FW), .VC_W(VW)) bus ();

  spidergon_traffic_gen #(
    .NUM_OF_NODES            (8),
    .FLIT_DATA_WIDTH         (FW),
    .NUM_OF_VIRTUAL_CHANNELS (2),
    .SRC_NODE                (0),
    .RESET_HOLD_CYCLES       (2),
    .NUM_FLITS               (16),
    .RUN_TIMEOUT             (30)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_pattern_sel(pattern_sel),
    .i_fixed_dest (fixed_dest),
    .o_noc_reset  (noc_reset),
    .flit_if      (bus.master),
    .o_sent_count (sent_count),
    .o_recv_count (recv_count),
    .o_done       (done),
    .o_pass       (pass),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pat;
    logic [2:0] fdest;
    int         ready_mode;   // 0: ready always 1, 1: toggle for 12 cycles then 1
    int         drop_idx;     // flit index never ejected (-1 none)
    int         corrupt_idx;  // flit index ejected with bit 0 flipped (-1 none)
    bit         exp_pass;
    bit         exp_timeout;
    int         exp_recv;
    int         exp_done;     // INJECT-relative cycle where done is first seen
  } vec_t;

  vec_t vecs[6];
  int   lfsr_exp[16];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_dest(input logic [1:0] pat, input logic [2:0] fd, input int k);
    case (pat)
      2'd0:    return int'(fd);
      2'd1:    return (k % 7) + 1;
      2'd2:    return 4;
      default: return lfsr_exp[k % 16];
    endcase
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic [FW-1:0] pd[64];
    bit            pv[64];
    logic [FW-1:0] d;
    logic [FW-1:0] hd;
    logic [VW-1:0] hv;
    bit            held;
    int            k;
    int            done_cyc;
    for (int i = 0; i < 64; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    k = 0;
    done_cyc = -1;
    held = 1'b0;
    hd = '0;
    hv = '0;
    @(negedge clk);
    pattern_sel = v.pat;
    fixed_dest = v.fdest;
    start = 1'b1;
    bus.flit_out_ready = 1'b0;
    bus.flit_in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_hold1_noc_reset", idx), 32'(noc_reset), 32'd1);
    check($sformatf("v%0d_hold1_valid", idx), 32'(bus.flit_out_valid), 32'd0);
    check($sformatf("v%0d_hold1_done", idx), 32'(done), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_hold2_noc_reset", idx), 32'(noc_reset), 32'd1);
    check($sformatf("v%0d_hold2_valid", idx), 32'(bus.flit_out_valid), 32'd0);
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check($sformatf("v%0d_inject_valid", idx), 32'(bus.flit_out_valid), 32'd1);
        check($sformatf("v%0d_inject_noc_reset", idx), 32'(noc_reset), 32'd0);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (held) begin
        check($sformatf("v%0d_stall_data_c%0d", idx, cyc), 32'(bus.flit_out_data), 32'(hd));
        check($sformatf("v%0d_stall_vc_c%0d", idx, cyc), 32'(bus.flit_out_vc), 32'(hv));
      end
      if (v.ready_mode == 0) bus.flit_out_ready = 1'b1;
      else bus.flit_out_ready = (cyc >= 12) || (cyc % 2 == 0);
      bus.flit_in_valid = pv[cyc];
      bus.flit_in_data = pd[cyc];
      held = 1'b0;
      if (bus.flit_out_valid) begin
        if (bus.flit_out_ready) begin
          d = bus.flit_out_data;
          check($sformatf("v%0d_dest_k%0d", idx, k), 32'(d[15:13]), 32'(exp_dest(v.pat, v.fdest, k)));
          check($sformatf("v%0d_seq_k%0d", idx, k), 32'(d[12:0]), 32'(k));
          check($sformatf("v%0d_vc_k%0d", idx, k), 32'(bus.flit_out_vc), 32'(k % 2));
          if (k != v.drop_idx && cyc + 3 < 64) begin
            pv[cyc+3] = 1'b1;
            pd[cyc+3] = (k == v.corrupt_idx) ? (d ^ 16'h0001) : d;
          end
          k++;
        end else begin
          held = 1'b1;
          hd = bus.flit_out_data;
          hv = bus.flit_out_vc;
        end
      end
    end
    bus.flit_out_ready = 1'b0;
    bus.flit_in_valid = 1'b0;
    check($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("v%0d_accepted", idx), 32'(k), 32'd16);
    check($sformatf("v%0d_sent_count", idx), 32'(sent_count), 32'd16);
    check($sformatf("v%0d_recv_count", idx), 32'(recv_count), 32'(v.exp_recv));
    check($sformatf("v%0d_pass", idx), 32'(pass), 32'(v.exp_pass));
    check($sformatf("v%0d_timeout", idx), 32'(timeout), 32'(v.exp_timeout));
    check($sformatf("v%0d_done_noc_reset", idx), 32'(noc_reset), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_hold", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_done_valid", idx), 32'(bus.flit_out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    lfsr_exp = '{7, 7, 3, 5, 2, 1, 4, 6, 3, 1, 4, 6, 3, 5, 2, 5};
    vecs[0] = '{pat: 2'd2, fdest: 3'd0, ready_mode: 0, drop_idx: -1, corrupt_idx: -1,
                exp_pass: 1'b1, exp_timeout: 1'b0, exp_recv: 16, exp_done: 19};
    vecs[1] = '{pat: 2'd1, fdest: 3'd0, ready_mode: 1, drop_idx: -1, corrupt_idx: -1,
                exp_pass: 1'b1, exp_timeout: 1'b0, exp_recv: 16, exp_done: 25};
    vecs[2] = '{pat: 2'd2, fdest: 3'd0, ready_mode: 0, drop_idx: 5, corrupt_idx: -1,
                exp_pass: 1'b0, exp_timeout: 1'b1, exp_recv: 15, exp_done: 30};
    vecs[3] = '{pat: 2'd2, fdest: 3'd0, ready_mode: 0, drop_idx: -1, corrupt_idx: 7,
                exp_pass: 1'b0, exp_timeout: 1'b0, exp_recv: 16, exp_done: 19};
    vecs[4] = '{pat: 2'd0, fdest: 3'd5, ready_mode: 0, drop_idx: -1, corrupt_idx: -1,
                exp_pass: 1'b1, exp_timeout: 1'b0, exp_recv: 16, exp_done: 19};
    vecs[5] = '{pat: 2'd3, fdest: 3'd0, ready_mode: 0, drop_idx: -1, corrupt_idx: -1,
                exp_pass: 1'b1, exp_timeout: 1'b0, exp_recv: 16, exp_done: 19};

    bus.flit_out_ready = 1'b0;
    bus.flit_in_valid = 1'b0;
    bus.flit_in_data = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_noc_reset", 32'(noc_reset), 32'd1);
    check("rst_valid", 32'(bus.flit_out_valid), 32'd0);
    check("rst_data", 32'(bus.flit_out_data), 32'd0);
    check("rst_vc", 32'(bus.flit_out_vc), 32'd0);
    check("rst_sent", 32'(sent_count), 32'd0);
    check("rst_recv", 32'(recv_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_noc_reset", 32'(noc_reset), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // 17th eject: the 16 expected flits plus a zero flit (checksum-neutral) land
    // during INJECT while ready is held off, so only the overflow can fail the run.
    @(negedge clk);
    pattern_sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    found = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("ovf_done_cycle", 32'(cyc), 32'd21);
        found = 1'b1;
        break;
      end
      bus.flit_out_ready = (cyc >= 5);
      bus.flit_in_valid = (cyc <= 16);
      bus.flit_in_data = (cyc < 16) ? {3'd4, 13'(cyc)} : 16'h0000;
    end
    bus.flit_out_ready = 1'b0;
    bus.flit_in_valid = 1'b0;
    check("ovf_done_seen", 32'(found), 32'd1);
    check("ovf_recv_count", 32'(recv_count), 32'd16);
    check("ovf_pass", 32'(pass), 32'd0);
    check("ovf_timeout", 32'(timeout), 32'd0);

    // Reset mid-INJECT at sent_count=5, then a clean rerun
    @(negedge clk);
    pattern_sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.flit_out_ready = 1'b1;
      if (sent_count == 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reach_sent5", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.flit_out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.flit_out_data), 32'd0);
    check("mid_rst_sent", 32'(sent_count), 32'd0);
    check("mid_rst_recv", 32'(recv_count), 32'd0);
    check("mid_rst_noc_reset", 32'(noc_reset), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.flit_out_ready = 1'b0;
    @(negedge clk);
    check("mid_idle_valid", 32'(bus.flit_out_valid), 32'd0);
    check("mid_idle_sent", 32'(sent_count), 32'd0);
    run_vec(6, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
